seven_seg_mux: RTL and testbench

Time-multiplexed driver for NUM_DIGITS hex seven-segment digits sharing one segment bus. It takes a packed hex value from the datapath and double-buffers it, updating only at frame boundaries so the display never tears. It then scans the digits at a programmable refresh rate, with per-digit blanking, decimal points, dead time between digits and configurable pin polarity. It sits between the ALU/result registers and the board display pins, and supersedes the single-digit combinational decoder.

---
 rtl/seven_seg_pkg.sv | 21 ++
 rtl/seven_seg_scan_timer.sv | 42 ++++
 rtl/seven_seg_mux.sv | 121 ++++++++++++
 tb/tb_seven_seg_mux.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and the active-high hex-to-segment table for the seven-segment display path.
package seven_seg_pkg;

  localparam int unsigned SEG_W    = 7;
  localparam int unsigned NIBBLE_W = 4;

  typedef logic [SEG_W-1:0] seg_t;

  // Bit order {g,f,e,d,c,b,a}, 1 = lit
  localparam seg_t SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic seg_t hex_to_seg(input logic [NIBBLE_W-1:0] nibble);
    return SEG_LUT[nibble];
  endfunction

endpackage

// File: rtl/seven_seg_scan_timer.sv
// Slot divider and digit scan counter; flags the dead-time window and the frame wrap cycle.
module seven_seg_scan_timer #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned DEAD_CYCLES = 1,
  localparam int unsigned DIV_W = $clog2(REFRESH_DIV),
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [DIV_W-1:0] div_cnt,
  output logic [IDX_W-1:0] digit_idx,
  output logic             slot_start,
  output logic             in_dead,
  output logic             frame_wrap
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic slot_end;

  always_comb begin
    slot_end   = (div_cnt == DIV_LAST);
    slot_start = (div_cnt == '0);
    in_dead    = (32'(div_cnt) < DEAD_CYCLES);
    frame_wrap = slot_end && (digit_idx == IDX_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      digit_idx <= '0;
    end else begin
      div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
      if (slot_end) begin
        digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_seg_mux.sv
// Double-buffered, time-multiplexed hex display driver with dead time and pin polarity control.
// Optional build macro LEADING_ZERO_BLANK_EN auto-blanks digits above the top nonzero nibble.
module seven_seg_mux
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter int unsigned DEAD_CYCLES    = 1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] value,
  input  logic                         load,
  input  logic [NUM_DIGITS-1:0]        blank_mask,
  input  logic [NUM_DIGITS-1:0]        dp_mask,
  output logic [SEG_W-1:0]             segment,
  output logic                         dp,
  output logic [NUM_DIGITS-1:0]        digit_sel,
  output logic                         frame_done
);

  localparam int unsigned VAL_W = NIBBLE_W * NUM_DIGITS;
  localparam int unsigned DIV_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [DIV_W-1:0]      div_cnt;
  logic [IDX_W-1:0]      digit_idx;
  logic                  slot_start;
  logic                  in_dead;
  logic                  frame_wrap;
  logic                  unused_slot_start;

  logic [VAL_W-1:0]      pending;
  logic [VAL_W-1:0]      shadow;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic [NIBBLE_W-1:0]   nibble;
  logic                  blank_now;
  seg_t                  seg_next;
  logic                  dp_next;
  logic [NUM_DIGITS-1:0] sel_next;

  seg_t                  seg_q;
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] sel_q;
  logic                  frame_done_q;

  seven_seg_scan_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .REFRESH_DIV(REFRESH_DIV),
    .DEAD_CYCLES(DEAD_CYCLES)
  ) u_scan_timer (
    .clk       (clk),
    .rst       (rst),
    .div_cnt   (div_cnt),
    .digit_idx (digit_idx),
    .slot_start(slot_start),
    .in_dead   (in_dead),
    .frame_wrap(frame_wrap)
  );

  assign unused_slot_start = slot_start;

  // Shadow only changes at the frame wrap so a frame never mixes two values
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      shadow  <= '0;
    end else begin
      if (load) begin
        pending <= value;
      end
      if (frame_wrap) begin
        shadow <= load ? value : pending;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    logic all_zero;
    lz_mask  = '0;
    all_zero = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
      all_zero   = all_zero && (shadow[NIBBLE_W*i +: NIBBLE_W] == '0);
      lz_mask[i] = all_zero;
    end
  end
`else
  assign lz_mask = '0;
`endif

  always_comb begin
    nibble    = shadow[NIBBLE_W*digit_idx +: NIBBLE_W];
    blank_now = blank_mask[digit_idx];
    seg_next  = (blank_now || lz_mask[digit_idx]) ? '0 : hex_to_seg(nibble);
    dp_next   = blank_now ? 1'b0 : dp_mask[digit_idx];
    sel_next  = in_dead ? '0 : (NUM_DIGITS'(1) << digit_idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q        <= '0;
      dp_q         <= 1'b0;
      sel_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      seg_q        <= seg_next;
      dp_q         <= dp_next;
      sel_q        <= sel_next;
      frame_done_q <= frame_wrap;
    end
  end

  assign segment    = seg_q ^ {SEG_W{SEG_ACTIVE_LOW}};
  assign dp         = dp_q ^ SEG_ACTIVE_LOW;
  assign digit_sel  = sel_q ^ {NUM_DIGITS{DIG_ACTIVE_LOW}};
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_mux.sv
// Directed plus random stimulus for seven_seg_mux checked against a cycle-count based model.
module tb_seven_seg_mux;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int DC = 1;
  localparam int FRAME = ND * RD;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic [3:0]  blank_mask;
  logic [3:0]  dp_mask;
  logic [6:0]  segment;
  logic        dp;
  logic [3:0]  digit_sel;
  logic        frame_done;

  always #5 clk = ~clk;

  seven_seg_mux #(
    .NUM_DIGITS    (ND),
    .REFRESH_DIV   (RD),
    .DEAD_CYCLES   (DC),
    .SEG_ACTIVE_LOW(1'b1),
    .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .value     (value),
    .load      (load),
    .blank_mask(blank_mask),
    .dp_mask   (dp_mask),
    .segment   (segment),
    .dp        (dp),
    .digit_sel (digit_sel),
    .frame_done(frame_done)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Model state: cycles since reset, plus the two value buffers
  int          cyc = 0;
  logic [15:0] m_pending = '0;
  logic [15:0] m_shadow = '0;
  logic [6:0]  lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    int         slot, idx, top;
    logic [3:0] nib;
    logic       wrap, dark_lz;
    logic [6:0] e_seg;
    logic       e_dp, e_fd;
    logic [3:0] e_sel;
    wrap = 1'b0;
    if (rst) begin
      e_seg = '0; e_dp = 1'b0; e_sel = '0; e_fd = 1'b0;
    end else begin
      slot = cyc % RD;
      idx  = (cyc / RD) % ND;
      wrap = (slot == RD - 1) && (idx == ND - 1);
      nib  = m_shadow[4*idx +: 4];
`ifdef LEADING_ZERO_BLANK_EN
      top = 0;
      for (int j = 0; j < ND; j++) if (m_shadow[4*j +: 4] != 4'h0) top = j;
      dark_lz = (idx > top);
`else
      top = 0;
      dark_lz = 1'b0;
`endif
      e_seg = (blank_mask[idx] || dark_lz) ? 7'h00 : lut[nib];
      e_dp  = blank_mask[idx] ? 1'b0 : dp_mask[idx];
      e_sel = (slot < DC) ? 4'h0 : 4'(1 << idx);
      e_fd  = wrap;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      cyc = 0; m_pending = '0; m_shadow = '0;
    end else begin
      if (wrap) m_shadow = load ? value : m_pending;
      if (load) m_pending = value;
      cyc++;
    end
    check("segment", segment, e_seg ^ 7'h7F);
    check("dp", dp, e_dp ^ 1'b1);
    check("digit_sel", digit_sel, e_sel ^ 4'hF);
    check("frame_done", frame_done, e_fd);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Advance until the next edge will sample the given position within the frame
  task automatic wait_phase(input int p);
    for (int k = 0; k < 2 * FRAME && (cyc % FRAME) != p; k++) step();
  endtask

  int         lit_phase [4] = '{1, 5, 9, 13};
  logic [6:0] lit_seg   [4] = '{7'h0E, 7'h30, 7'h08, 7'h79};  // pins for F,3,A,1
  logic [3:0] lit_sel   [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  initial begin
    rst = 1'b1; load = 1'b0; value = '0; blank_mask = '0; dp_mask = '0;
    run(20);
    check("reset_segment", segment, 7'h7F);
    check("reset_digit_sel", digit_sel, 4'hF);
    rst = 1'b0;

    value = 16'h1A3F; load = 1'b1; step(); load = 1'b0;
    run(2 * FRAME);
    for (int d = 0; d < 4; d++) begin
      wait_phase(lit_phase[d]);
      step();
      check("lit_seg", segment, lit_seg[d]);
      check("lit_sel", digit_sel, lit_sel[d]);
    end

    wait_phase(3);
    value = 16'h1111; load = 1'b1; step(); load = 1'b0;
    run(3);
    value = 16'h2222; load = 1'b1; step(); load = 1'b0;
    run(FRAME + 4);

    wait_phase(FRAME - 1);
    value = 16'h00FF; load = 1'b1; step(); load = 1'b0;
    run(FRAME);

    blank_mask = 4'b0100; dp_mask = 4'b0001;
    run(FRAME);
    wait_phase(9); step();
    check("blank_seg_dig2", segment, 7'h7F);
    check("blank_dp_dig2", dp, 1'b1);
    wait_phase(1); step();
    check("dp_lit_dig0", dp, 1'b0);
    blank_mask = '0; dp_mask = '0;

    wait_phase(9);
    rst = 1'b1; step(); rst = 1'b0;
    check("midrst_digit_sel", digit_sel, 4'hF);
    run(FRAME + 2);

    value = 16'h0042; load = 1'b1; step(); load = 1'b0;
    run(2 * FRAME);
    value = 16'h0000; load = 1'b1; step(); load = 1'b0;
    run(2 * FRAME);

    for (int k = 0; k < 400; k++) begin
      rst        = ($urandom_range(0, 59) == 0);
      load       = ($urandom_range(0, 5) == 0);
      value      = 16'($urandom);
      blank_mask = 4'($urandom);
      dp_mask    = 4'($urandom);
      step();
    end
    rst = 1'b0; load = 1'b0;
    run(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
